// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit active-low seven-segment display.
// Optional LEADING_ZERO_BLANK_EN: darken leading zero digits 3..1 of the latched value.
module seg_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  blank_mask_i,
  input  logic [3:0]  dp_i,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BLANK_LAST = BLANK_CYCLES - 1;
  localparam int unsigned ACTIVE_LAST = DWELL_CYCLES - BLANK_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        sh_value_q, sh_value_d;
  logic [3:0]         sh_mask_q, sh_mask_d;
  logic [3:0]         sh_dp_q, sh_dp_d;
  logic [3:0]         an_d;
  logic [6:0]         seg_d;
  logic               dp_d;
  logic               tick_d;
  logic [3:0]         lz;
  logic [3:0]         nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  // Leading-zero suppression flags for the value being latched/displayed
  always_comb begin
    lz = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    lz[3] = (sh_value_d[15:12] == 4'h0);
    lz[2] = lz[3] & (sh_value_d[11:8] == 4'h0);
    lz[1] = lz[2] & (sh_value_d[7:4] == 4'h0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      sh_value_q <= 16'h0000;
      sh_mask_q  <= 4'h0;
      sh_dp_q    <= 4'h0;
      an_n       <= 4'hF;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sh_value_q <= sh_value_d;
      sh_mask_q  <= sh_mask_d;
      sh_dp_q    <= sh_dp_d;
      an_n       <= an_d;
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      frame_tick <= tick_d;
    end
  end

  // Next state, and outputs for the state being entered so registers show it without lag
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CNT_W'(1);
    sh_value_d = sh_value_q;
    sh_mask_d  = sh_mask_q;
    sh_dp_d    = sh_dp_q;
    tick_d     = 1'b0;
    an_d       = 4'hF;
    seg_d      = 7'h7F;
    dp_d       = 1'b1;
    nib        = 4'h0;

    if (!enable_i) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = BLANK;
          idx_d      = 2'd0;
          cnt_d      = '0;
          sh_value_d = value_i;
          sh_mask_d  = blank_mask_i;
          sh_dp_d    = dp_i;
        end
        BLANK: begin
          if (cnt_q == CNT_W'(BLANK_LAST)) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end
        end
        ACTIVE: begin
          if (cnt_q == CNT_W'(ACTIVE_LAST)) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            // Frame boundary: pulse and latch a fresh display value
            if (idx_q == 2'd3) begin
              tick_d     = 1'b1;
              sh_value_d = value_i;
              sh_mask_d  = blank_mask_i;
              sh_dp_d    = dp_i;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end

    if (state_d == ACTIVE) begin
      nib   = sh_value_d[{idx_d, 2'b00} +: 4];
      an_d  = (sh_mask_d[idx_d] | lz[idx_d]) ? 4'hF : ~(4'b0001 << idx_d);
      seg_d = decode(nib);
      dp_d  = ~sh_dp_d[idx_d];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL_CYCLES=10, BLANK_CYCLES=2.
// Follows LEADING_ZERO_BLANK_EN the same way the RTL build does.
module tb_seg_scan_ctrl;

  localparam int unsigned DW = 10;
  localparam int unsigned BL = 2;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic [15:0] value_i;
  logic [3:0]  blank_mask_i;
  logic [3:0]  dp_i;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  seg_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .value_i(value_i),
    .blank_mask_i(blank_mask_i), .dp_i(dp_i), .an_n(an_n), .seg_n(seg_n),
    .dp_n(dp_n), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs plus hand-decoded segment patterns {digit3, digit2, digit1, digit0}
  typedef struct {
    logic [15:0] value;
    logic [3:0]  mask;
    logic [3:0]  dp;
    logic [27:0] exp_seg;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got an/seg/dp/tick=%b/%h/%b/%b want %b/%h/%b/%b", name,
               act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // Checks ncyc consecutive cycles of a frame from its first blank cycle
  task automatic check_frame(input vec_t v, input bit tick_first, input int ncyc,
                             input int chg_at, input logic [15:0] chg_val);
    logic [3:0] dark;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    int slot, pos;
    dark = v.mask;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < 4; k++)
      if ((v.value >> (4 * k)) == 16'h0) dark[k] = 1'b1;
`endif
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      slot = c / DW;
      pos  = c % DW;
      if (pos < BL) begin
        an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
      end else begin
        an_e  = dark[slot] ? 4'hF : ~(4'b0001 << slot);
        seg_e = v.exp_seg[slot*7 +: 7];
        dp_e  = ~v.dp[slot];
      end
      check($sformatf("frame %h cyc %0d", v.value, c), {an_n, seg_n, dp_n, frame_tick},
            {an_e, seg_e, dp_e, (c == 0) && tick_first});
      if (c == chg_at) value_i = chg_val;
    end
  endtask

  task automatic start(input vec_t v);
    @(negedge clk);
    enable_i = 1'b0;
    @(negedge clk);
    value_i = v.value; blank_mask_i = v.mask; dp_i = v.dp; enable_i = 1'b1;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h5678, 4'b0000, 4'b1010, {7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[2] = '{16'h9ABC, 4'b0000, 4'b0101, {7'h10, 7'h08, 7'h03, 7'h46}};
    vecs[3] = '{16'hDEF0, 4'b1001, 4'b1111, {7'h21, 7'h06, 7'h0E, 7'h40}};
    vecs[4] = '{16'h0070, 4'b0000, 4'b0000, {7'h40, 7'h40, 7'h78, 7'h40}};
    vecs[5] = '{16'h1234, 4'b0100, 4'b0001, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[6] = '{16'hFFFF, 4'b0000, 4'b0000, {7'h0E, 7'h0E, 7'h0E, 7'h0E}};

    rst_n = 1'b1; enable_i = 1'b0; value_i = '0; blank_mask_i = '0; dp_i = '0;
    #1 rst_n = 1'b0;
    #1 check("reset", {an_n, seg_n, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle dark", {an_n, seg_n, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});

    // Two frames per table entry; the second starts with the frame_tick pulse
    for (int i = 0; i < 6; i++) begin
      start(vecs[i]);
      check_frame(vecs[i], 1'b0, 4 * DW, -1, 16'h0);
      check_frame(vecs[i], 1'b1, 4 * DW, -1, 16'h0);
    end

    // Mid-frame value change is held off until the next frame reload
    start(vecs[0]);
    check_frame(vecs[0], 1'b0, 4 * DW, 13, vecs[6].value);
    check_frame(vecs[6], 1'b1, 4 * DW, -1, 16'h0);

    // Enable dropped three cycles into digit 2 active, then restart
    start(vecs[0]);
    check_frame(vecs[0], 1'b0, 2 * DW + BL + 3, -1, 16'h0);
    enable_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("disable dark", {an_n, seg_n, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    value_i = vecs[1].value; blank_mask_i = vecs[1].mask; dp_i = vecs[1].dp;
    enable_i = 1'b1;
    check_frame(vecs[1], 1'b0, 4 * DW, -1, 16'h0);

    // Asynchronous reset in the middle of digit 0 active
    start(vecs[2]);
    check_frame(vecs[2], 1'b0, 5, -1, 16'h0);
    #2 rst_n = 1'b0;
    #1 check("async reset", {an_n, seg_n, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    start(vecs[0]);
    check_frame(vecs[0], 1'b0, 4 * DW, -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
